core_seq: RTL
=============

// Module: core_seq
// PURPOSE
//   Multi-cycle sequencer for the RV32 core. It replaces the single-cycle "fetch+execute every clock" flow with
//   valid/ready fetch and load/store bus handshakes, holds the PC and instruction register, and gates reg/CSR
//   write strobes to one commit cycle. Halts on ebreak, bus timeout, or misaligned next PC.
// PARAMETERS
//   XLEN      32            datapath/address width
//   RESET_PC  32'h8000_0000 PC value after reset
//   TIMEOUT   255           max cycles waiting for a bus response (>=1)
// PORTS
//   clk            in   1     clock
//   rst            in   1     synchronous active-high reset
//   ifu_req_valid  out  1     fetch request valid
//   ifu_req_ready  in   1     fetch request accepted
//   ifu_addr       out  XLEN  fetch address (= pc)
//   ifu_rsp_valid  in   1     fetch data valid
//   ifu_rdata      in   32    fetched instruction
//   pc             out  XLEN  current PC
//   inst           out  32    instruction register (to IDU)
//   dec_is_load    in   1     decoded load
//   dec_is_store   in   1     decoded store
//   exu_npc        in   XLEN  next PC from EXU/CSR mux, stable while inst held
//   exu_reg_wen    in   1     EXU wants GPR write
//   exu_csr_wen    in   1     EXU wants CSR write
//   lsu_req_valid  out  1     load/store request valid
//   lsu_req_ready  in   1     load/store request accepted
//   lsu_rsp_valid  in   1     load data / store ack
//   reg_wen        out  1     gated GPR write strobe (1-cycle pulse)
//   csr_wen        out  1     gated CSR write strobe (1-cycle pulse)
//   exit           out  1     core halted (halt_cause != 0)
//   halt_cause     out  2     0 run, 1 ebreak, 2 bus timeout, 3 misaligned PC
//   cycle_cnt      out  64    cycle counter (see CONFIGURATION)
//   instret_cnt    out  64    retired instruction counter (see CONFIGURATION)
// BEHAVIOUR
//   Reset: state=F_REQ, pc=RESET_PC, inst=32'h0000_0013, halt_cause=0, tmo=0, all strobes/valids 0.
//   F_REQ : ifu_req_valid=1; on ifu_req_ready -> F_WAIT, tmo<=0.
//   F_WAIT: on ifu_rsp_valid, inst<=ifu_rdata -> EXEC; else tmo++; tmo==TIMEOUT -> HALT, cause 2.
//   EXEC  : inst==32'h0010_0073 -> HALT, cause 1, no strobes.
//           load|store -> M_REQ.
//           otherwise commit: reg_wen=exu_reg_wen, csr_wen=exu_csr_wen, pc<=exu_npc -> F_REQ.
//   M_REQ : lsu_req_valid=1; on lsu_req_ready -> M_WAIT, tmo<=0.
//   M_WAIT: on lsu_rsp_valid commit: reg_wen=dec_is_load, csr_wen=0, pc<=exu_npc -> F_REQ.
//           Timeout as F_WAIT -> HALT, cause 2.
//   HALT  : sticky until rst; all valids/strobes 0; pc and inst frozen.
//   Commit check: exu_npc[1:0]!=0 -> HALT, cause 3, strobes suppressed, pc unchanged.
//   Commit = instruction retires. reg_wen/csr_wen asserted only in the commit cycle, combinationally.
//   Responses arriving outside F_WAIT/M_WAIT are ignored. Response is never accepted in the REQ cycle.
//   Valid stays asserted (address stable) until ready; never withdrawn.
//   Latency, zero-wait bus (ready same cycle, rsp next cycle): ALU op = 3 cycles; load/store = 5 cycles.
//   rst mid-transaction: state/pc reset next edge; outstanding bus responses afterwards fall in F_REQ and are dropped.
//   tmo width $clog2(TIMEOUT+1); saturates, never wraps.
// CONFIGURATION
//   PERF_CNT_EN defined:
//     cycle_cnt increments every cycle not in HALT.
//     instret_cnt increments on each commit.
//     Both 64-bit wrapping, reset to 0.
//   PERF_CNT_EN undefined: cycle_cnt and instret_cnt tied to 0, no counter flops.
// TESTING
//   addi stream, ready=1, rsp 1 cycle later -> one commit every 3 cycles; pc 0x8000_0000,_04,_08; reg_wen pulses.
//   Fetch ready held low 4 cycles -> ifu_req_valid and ifu_addr stable throughout; no state advance.
//   lw, lsu rsp after 2 wait cycles -> single reg_wen pulse in the rsp cycle.
//   sw -> reg_wen stays 0 through retire.
//   ebreak fetched -> exit=1, halt_cause=1 next cycle; later ifu_rsp_valid ignored; rst -> pc=RESET_PC.
//   TIMEOUT=3, no fetch response -> HALT, cause 2, after 3 wait cycles.
//   jalr giving exu_npc=0x8000_0102 -> cause 3, no reg_wen, pc unchanged.
//   PERF_CNT_EN: 10 addi at zero wait -> instret_cnt=10, cycle_cnt=30.
//   Without PERF_CNT_EN: both counters read 0.

Source files
------------

// File: rtl/core_seq.sv
// core_seq -- multi-cycle sequencer for the RV32 core.
//
// Drives the fetch and load/store bus handshakes (valid/ready request,
// single-beat response), holds the PC and instruction register, and gates
// the GPR/CSR write strobes so they pulse only in the cycle an instruction
// retires. The core halts (sticky until rst) on ebreak, on a bus response
// that fails to arrive within TIMEOUT wait cycles, or on a misaligned next PC.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   ifu_req_valid/ifu_req_ready      fetch request handshake, ifu_addr = pc
//   ifu_rsp_valid/ifu_rdata          fetch response
//   pc, inst                         current PC and instruction register
//   dec_is_load/dec_is_store         decode of inst
//   exu_npc, exu_reg_wen, exu_csr_wen  EXU next PC and write requests
//   lsu_req_valid/ready, lsu_rsp_valid load/store handshake
//   reg_wen, csr_wen                 gated write strobes (commit cycle only)
//   exit, halt_cause                 halted flag; 0 run, 1 ebreak, 2 timeout, 3 misaligned
//   cycle_cnt, instret_cnt           performance counters
//
// Build option: define PERF_CNT_EN to implement the 64-bit cycle/instret
// counters; otherwise both outputs are tied to zero and no flops are built.

module core_seq #(
   parameter int unsigned          XLEN     = 32,
   parameter logic [XLEN-1:0]      RESET_PC = 32'h8000_0000,
   parameter int unsigned          TIMEOUT  = 255
) (
   input  logic            clk,
   input  logic            rst,
   output logic            ifu_req_valid,
   input  logic            ifu_req_ready,
   output logic [XLEN-1:0] ifu_addr,
   input  logic            ifu_rsp_valid,
   input  logic [31:0]     ifu_rdata,
   output logic [XLEN-1:0] pc,
   output logic [31:0]     inst,
   input  logic            dec_is_load,
   input  logic            dec_is_store,
   input  logic [XLEN-1:0] exu_npc,
   input  logic            exu_reg_wen,
   input  logic            exu_csr_wen,
   output logic            lsu_req_valid,
   input  logic            lsu_req_ready,
   input  logic            lsu_rsp_valid,
   output logic            reg_wen,
   output logic            csr_wen,
   output logic            exit,
   output logic [1:0]      halt_cause,
   output logic [63:0]     cycle_cnt,
   output logic [63:0]     instret_cnt
);

   localparam int unsigned   TW        = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [31:0]   EBREAK    = 32'h0010_0073;
   localparam logic [31:0]   NOP       = 32'h0000_0013;

   typedef enum logic [2:0] {F_REQ, F_WAIT, EXEC, M_REQ, M_WAIT, HALT} state_t;

   state_t          state, state_nxt;
   logic [XLEN-1:0] pc_nxt;
   logic [31:0]     inst_nxt;
   logic [1:0]      cause_nxt;
   logic [TW-1:0]   tmo, tmo_nxt;
   logic            commit;
   logic            want_commit, want_reg, want_csr;

   assign ifu_addr = pc;
   assign exit     = (halt_cause != 2'd0);

   always_comb begin
      state_nxt     = state;
      pc_nxt        = pc;
      inst_nxt      = inst;
      cause_nxt     = halt_cause;
      tmo_nxt       = tmo;
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      reg_wen       = 1'b0;
      csr_wen       = 1'b0;
      commit        = 1'b0;
      want_commit   = 1'b0;
      want_reg      = 1'b0;
      want_csr      = 1'b0;

      case (state)
         F_REQ: begin
            ifu_req_valid = 1'b1;
            if (ifu_req_ready) begin
               state_nxt = F_WAIT;
               tmo_nxt   = '0;
            end
         end
         F_WAIT: begin
            if (ifu_rsp_valid) begin
               inst_nxt  = ifu_rdata;
               state_nxt = EXEC;
            end else begin
               if (tmo != TMO_MAX) tmo_nxt = tmo + 1'b1;
               // This wait cycle is the TIMEOUT-th without a response.
               if (tmo >= TMO_LAST) begin
                  state_nxt = HALT;
                  cause_nxt = 2'd2;
               end
            end
         end
         EXEC: begin
            if (inst == EBREAK) begin
               state_nxt = HALT;
               cause_nxt = 2'd1;
            end else if (dec_is_load || dec_is_store) begin
               state_nxt = M_REQ;
            end else begin
               want_commit = 1'b1;
               want_reg    = exu_reg_wen;
               want_csr    = exu_csr_wen;
            end
         end
         M_REQ: begin
            lsu_req_valid = 1'b1;
            if (lsu_req_ready) begin
               state_nxt = M_WAIT;
               tmo_nxt   = '0;
            end
         end
         M_WAIT: begin
            if (lsu_rsp_valid) begin
               want_commit = 1'b1;
               want_reg    = dec_is_load;
            end else begin
               if (tmo != TMO_MAX) tmo_nxt = tmo + 1'b1;
               if (tmo >= TMO_LAST) begin
                  state_nxt = HALT;
                  cause_nxt = 2'd2;
               end
            end
         end
         default: ; // HALT: everything frozen
      endcase

      // Shared retire path for ALU ops and memory ops; a misaligned target
      // turns the retire into a halt with the strobes suppressed.
      if (want_commit) begin
         if (exu_npc[1:0] != 2'b00) begin
            state_nxt = HALT;
            cause_nxt = 2'd3;
         end else begin
            reg_wen   = want_reg;
            csr_wen   = want_csr;
            pc_nxt    = exu_npc;
            state_nxt = F_REQ;
            commit    = 1'b1;
         end
      end

      // Keep the bus and register file quiet while reset is held.
      if (rst) begin
         ifu_req_valid = 1'b0;
         lsu_req_valid = 1'b0;
         reg_wen       = 1'b0;
         csr_wen       = 1'b0;
         commit        = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= F_REQ;
         pc         <= RESET_PC;
         inst       <= NOP;
         halt_cause <= 2'd0;
         tmo        <= '0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         inst       <= inst_nxt;
         halt_cause <= cause_nxt;
         tmo        <= tmo_nxt;
      end
   end

`ifdef PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         if (state != HALT) cycle_cnt <= cycle_cnt + 64'd1;
         if (commit)        instret_cnt <= instret_cnt + 64'd1;
      end
   end
`else
   assign cycle_cnt   = '0;
   assign instret_cnt = '0;
`endif

endmodule
